pulse_window_counter: RTL and testbench
=======================================

# pulse_window_counter

Front end of the pulse monitor datapath: the block that produces the four per-window pulse counts that the averaging stage consumes. It synchronizes the raw pulse input, counts rising edges over consecutive measurement windows delimited by an external window strobe, and keeps a 4-deep history of completed window counts. It presents that history as count1..count4 with a valid flag, so the downstream averager only operates on a full history.

## Interface
- CNT_W, 8, width of the window counter and of each history entry; must match the averager input width.
- clk  input  1  system clock (100 MHz on the NEXYS A7).
- rst  input  1  reset; asynchronous assert, active-high; clears all state.
- pulse_in  input  1  raw pulse from the sensor conditioning; asynchronous to clk.
- tick_window  input  1  one-cycle strobe marking the end of a measurement window; synchronous to clk.
- clr  input  1  synchronous clear of the counter and history.
- cur_count  output  CNT_W  running edge count of the open window.
- count1  output  CNT_W  most recently completed window count.
- count2  output  CNT_W  second most recent window count.
- count3  output  CNT_W  third most recent window count.
- count4  output  CNT_W  oldest retained window count.
- hist_valid  output  1  high once four windows have completed since the last reset or clr.

## Operation
- Input path: two-flop synchronizer (s1, s2) followed by a history flop s3. edge = s2 & ~s3. Only rising edges are counted.
- Counter: increments on each cycle with edge = 1 and saturates at 2^CNT_W-1. There is no wrap-around.
- Window close: on a cycle with tick_window = 1, the history shifts (count4<=count3, count3<=count2, count2<=count1) and count1 takes the closing value. The closing value is cur_count+edge, saturated. cur_count then restarts at 0.
- Simultaneous edge and tick: the edge belongs to the closing window. The new window starts at 0, not 1.
- Fill tracking: a 3-bit fill counter counts ticks and saturates at 4. hist_valid = (fill == 4).
- Fill state sequence: EMPTY(0) -> 1 -> 2 -> 3 -> FULL(4). Each transition occurs on a tick. FULL holds on further ticks. Any state returns to EMPTY on clr or rst.
- clr: zeroes the counter, the history and the fill counter, and deasserts hist_valid. clr has priority over tick_window and edge in the same cycle. The synchronizer flops are not cleared, so an edge already in flight is counted in the new window only if it arrives after the clr cycle.
- Reset values: cur_count=0, count1..count4=0, hist_valid=0, and s1, s2, s3 = 0. All outputs are registered.
- Back-to-back ticks are legal. A window with no edges records 0.

## Timing
- Edge latency: a rising pulse_in sampled at clock edge k causes cur_count to increment at edge k+2 (visible in the cycle after k+2).
- Minimum pulse_in high and low widths are 2 clk periods each for guaranteed counting. Shorter pulses may be missed.
- Tick latency: count1..count4, hist_valid and cur_count=0 all update at the clock edge that samples tick_window = 1.
- hist_valid rises at the edge sampling the 4th tick after reset or clr.
- Asynchronous rst: outputs go to their reset values immediately, without waiting for clk. Release of rst is synchronous to the system reset tree.
- Mid-window rst or clr: the partial count is discarded and is not pushed into the history.

## Test plan
- Reset/idle: assert rst mid-stream with cur_count=5 -> all outputs 0 immediately. After release with no pulses and 4 ticks -> count1..count4 = 0 and hist_valid = 1 after the 4th tick.
- Fill and shift: 10, 20, 30, 40 pulses in four windows (pulses 4 cycles high/4 low, window 400 cycles) -> count1=40, count2=30, count3=20, count4=10, hist_valid=1. A fifth window of 50 pulses -> count1=50, count4=20.
- Saturation: 300 pulses in one window with CNT_W=8 -> cur_count holds at 255 and count1 = 255 after the tick.
- Edge on tick: tick_window coincides with the cycle where edge=1 and cur_count=7 -> count1=8 and cur_count=0 in the next cycle.
- clr priority: clr and tick_window asserted together with fill=3 and cur_count=9 -> all counts 0, hist_valid=0, and the next tick gives fill 1.
- Short pulse and latency: a pulse_in high pulse aligned to 1 clk -> a count is not required. A pulse rising before edge k -> cur_count increments at edge k+2 exactly, checked cycle by cycle.

Source files
------------

// File: rtl/pulse_window_counter.sv
// -----------------------------------------------------------------------------
// pulse_window_counter
//
// Front end of the pulse monitor datapath. The raw sensor pulse is brought into
// the clk domain through a two-flop synchronizer. Its rising edges are counted
// over measurement windows that end on each tick_window strobe. A 4-deep
// history of completed window counts is kept for the averaging stage.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset; clears all state
//   pulse_in     raw pulse, asynchronous to clk
//   tick_window  one-cycle strobe closing the current window
//   clr          synchronous clear of the counter, history and fill tracking
//   cur_count    running (saturating) edge count of the open window
//   count1..4    completed window counts, count1 newest, count4 oldest
//   hist_valid   high once four windows have closed since rst/clr
// -----------------------------------------------------------------------------
module pulse_window_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             tick_window,
    input  logic             clr,
    output logic [CNT_W-1:0] cur_count,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] count3,
    output logic [CNT_W-1:0] count4,
    output logic             hist_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [2:0]       FILL_EMPTY = 3'd0;
    localparam logic [2:0]       FILL_FULL  = 3'd4;

    // Synchronizer (s1, s2) plus the history flop s3 used for edge detection.
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    logic [CNT_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W-1:0] hist_d [4];
    logic [2:0]       fill_q, fill_d;
    logic             valid_q, valid_d;

    logic             pulse_edge;
    logic [CNT_W-1:0] count_inc;   // cur_q plus this cycle's edge, saturated

    always_comb begin
        s1_d       = pulse_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        pulse_edge = s2_q & ~s3_q;
        count_inc  = cur_q;
        if (pulse_edge && (cur_q != CNT_MAX)) begin
            count_inc = cur_q + CNT_W'(1);
        end
    end

    // The newest history slot takes the closing value, which already includes
    // an edge landing on the tick cycle; the new window therefore starts at 0.
    assign hist_d[0] = clr         ? '0 :
                       tick_window ? count_inc : hist_q[0];

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_hist_shift
            assign hist_d[gi] = clr         ? '0 :
                                tick_window ? hist_q[gi-1] : hist_q[gi];
        end
    endgenerate

    // clr outranks tick_window and edge: the open window is simply discarded.
    always_comb begin
        cur_d  = count_inc;
        fill_d = fill_q;
        if (clr) begin
            cur_d  = '0;
            fill_d = FILL_EMPTY;
        end else if (tick_window) begin
            cur_d = '0;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 3'd1;
            end
        end
        valid_d = (fill_d == FILL_FULL);
    end

    // Synchronizer flops are reset by rst only; clr leaves an in-flight edge
    // alone so it lands in whichever window is open when it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cur_q   <= '0;
            fill_q  <= FILL_EMPTY;
            valid_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cur_q   <= cur_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hist_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist_q[gi] <= '0;
                end else begin
                    hist_q[gi] <= hist_d[gi];
                end
            end
        end
    endgenerate

    assign cur_count  = cur_q;
    assign count1     = hist_q[0];
    assign count2     = hist_q[1];
    assign count3     = hist_q[2];
    assign count4     = hist_q[3];
    assign hist_valid = valid_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// -----------------------------------------------------------------------------
// tb_pulse_window_counter
//
// Table of window records (pulse count -> expected history) plus hand-written
// sequences for reset, edge-on-tick, clr priority and edge latency. Every tick
// also pushes the bench's own count of driven pulses onto a scoreboard queue,
// which is popped and compared against count1 once the tick has been taken.
// -----------------------------------------------------------------------------
module tb_pulse_window_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       tick_window = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] cur_count, count1, count2, count3, count4;
    logic       hist_valid;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_total = 0;
    logic [7:0] sb_q [$];

    typedef struct {
        int pulses;
        int cur;
        int c1, c2, c3, c4;
        int hv;
    } win_vec_t;

    pulse_window_counter #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .tick_window(tick_window),
        .clr        (clr),
        .cur_count  (cur_count),
        .count1     (count1),
        .count2     (count2),
        .count3     (count3),
        .count4     (count4),
        .hist_valid (hist_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 4 cycles high, 4 cycles low per pulse.
    task automatic drive_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = 1'b1;
            repeat (4) step();
            pulse_in = 1'b0;
            repeat (4) step();
            pulse_total++;
        end
    endtask

    task automatic check_all(input string tag, input int cur, input int c1,
                             input int c2, input int c3, input int c4, input int hv);
        check({tag, ".cur_count"}, int'(cur_count), cur);
        check({tag, ".count1"}, int'(count1), c1);
        check({tag, ".count2"}, int'(count2), c2);
        check({tag, ".count3"}, int'(count3), c3);
        check({tag, ".count4"}, int'(count4), c4);
        check({tag, ".hist_valid"}, int'(hist_valid), hv);
    endtask

    // Close the window: push the expected closing value, take the tick, then
    // pop and compare against count1.
    task automatic tick_once(input string tag);
        logic [7:0] exp_c1;
        sb_q.push_back((pulse_total > 255) ? 8'd255 : 8'(pulse_total));
        tick_window = 1'b1;
        step();
        tick_window = 1'b0;
        pulse_total = 0;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            exp_c1 = sb_q.pop_front();
            check({tag, ".sb_count1"}, int'(count1), int'(exp_c1));
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        pulse_total = 0;
    endtask

    win_vec_t vecs [7];

    initial begin
        vecs[0] = '{pulses: 10,  cur: 10,  c1: 10,  c2: 0,   c3: 0,  c4: 0,  hv: 0};
        vecs[1] = '{pulses: 20,  cur: 20,  c1: 20,  c2: 10,  c3: 0,  c4: 0,  hv: 0};
        vecs[2] = '{pulses: 30,  cur: 30,  c1: 30,  c2: 20,  c3: 10, c4: 0,  hv: 0};
        vecs[3] = '{pulses: 40,  cur: 40,  c1: 40,  c2: 30,  c3: 20, c4: 10, hv: 1};
        vecs[4] = '{pulses: 50,  cur: 50,  c1: 50,  c2: 40,  c3: 30, c4: 20, hv: 1};
        vecs[5] = '{pulses: 300, cur: 255, c1: 255, c2: 50,  c3: 40, c4: 30, hv: 1};
        vecs[6] = '{pulses: 0,   cur: 0,   c1: 0,   c2: 255, c3: 50, c4: 40, hv: 1};

        // Reset state.
        repeat (2) step();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // Asynchronous reset mid-window with cur_count = 5.
        drive_pulses(5);
        check("pre_rst.cur_count", int'(cur_count), 5);
        #3 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        pulse_total = 0;
        step();

        // Four empty windows: history of zeros, valid only after the fourth.
        for (int i = 0; i < 4; i++) begin
            repeat (3) step();
            tick_once("idle_tick");
            check($sformatf("idle_tick%0d.hist_valid", i + 1), int'(hist_valid), (i == 3) ? 1 : 0);
        end
        check_all("idle_hist", 0, 0, 0, 0, 0, 1);

        do_clr();
        check_all("clr", 0, 0, 0, 0, 0, 0);

        // Table: fill, shift and saturation.
        for (int v = 0; v < 7; v++) begin
            drive_pulses(vecs[v].pulses);
            check($sformatf("win%0d.pre_tick.cur_count", v), int'(cur_count), vecs[v].cur);
            tick_once($sformatf("win%0d", v));
            check_all($sformatf("win%0d", v), 0, vecs[v].c1, vecs[v].c2,
                      vecs[v].c3, vecs[v].c4, vecs[v].hv);
        end

        // Edge coincides with tick: cur_count = 7, closing value 8.
        drive_pulses(7);
        check("eot.pre.cur_count", int'(cur_count), 7);
        pulse_in = 1'b1;
        step();
        step();                 // s2 = 1, s3 = 0: edge is high this cycle
        pulse_total++;
        tick_once("eot");
        check("eot.count1", int'(count1), 8);
        check("eot.cur_count", int'(cur_count), 0);
        step();
        check("eot.next.cur_count", int'(cur_count), 0);
        pulse_in = 1'b0;
        repeat (4) step();

        // clr together with tick at fill = 3, cur_count = 9.
        do_clr();
        for (int i = 0; i < 3; i++) tick_once("clrp_fill");
        drive_pulses(9);
        check("clrp.pre.cur_count", int'(cur_count), 9);
        check("clrp.pre.hist_valid", int'(hist_valid), 0);
        clr = 1'b1;
        tick_window = 1'b1;
        step();
        clr = 1'b0;
        tick_window = 1'b0;
        pulse_total = 0;
        check_all("clrp", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick_once("clrp_after");
            check($sformatf("clrp_after%0d.hist_valid", i + 1), int'(hist_valid), (i == 3) ? 1 : 0);
        end

        // One-cycle pulse: counting not required, so close that window unscored.
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        repeat (4) step();
        tick_window = 1'b1;
        step();
        tick_window = 1'b0;
        pulse_total = 0;
        check("short.cur_count", int'(cur_count), 0);

        // Edge latency: rise before edge k=1 -> increment visible after edge 3.
        pulse_in = 1'b1;
        step();
        check("lat.k1.cur_count", int'(cur_count), 0);
        step();
        check("lat.k2.cur_count", int'(cur_count), 0);
        step();
        check("lat.k3.cur_count", int'(cur_count), 1);
        step();
        check("lat.k4.cur_count", int'(cur_count), 1);
        pulse_in = 1'b0;
        repeat (4) step();
        check("lat.end.cur_count", int'(cur_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
